// File: rtl/cpu6_trap_ctrl_if.sv
// rtl/cpu6_trap_ctrl_if.sv - trap sequencer bus between the cpu6 pipeline and the trap controller
interface cpu6_trap_ctrl_if #(
    parameter int XLEN = 32,
    parameter int NIRQ = 4
);
    logic [NIRQ-1:0] irq_pending;
    logic [NIRQ-1:0] irq_enable;
    logic            mstatus_mie;
    logic            excp_illinstr;
    logic            mret;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            drain_req;
    logic            drain_ack;
    logic            stall_f;
    logic            kill_d;
    logic            flush_pc_ena;
    logic [XLEN-1:0] flush_pc;
    logic            mepc_we;
    logic [XLEN-1:0] mepc_wdata;
    logic            mcause_we;
    logic [XLEN-1:0] mcause_wdata;
    logic            mstatus_trap;
    logic            mstatus_mret;
    logic            busy;

    // Trap controller side
    modport master (
        input  irq_pending, irq_enable, mstatus_mie, excp_illinstr, mret,
               pc_d, csr_mtvec, csr_mepc, drain_ack,
        output drain_req, stall_f, kill_d, flush_pc_ena, flush_pc,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata,
               mstatus_trap, mstatus_mret, busy
    );

    // Pipeline / CSR file side
    modport slave (
        output irq_pending, irq_enable, mstatus_mie, excp_illinstr, mret,
               pc_d, csr_mtvec, csr_mepc, drain_ack,
        input  drain_req, stall_f, kill_d, flush_pc_ena, flush_pc,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata,
               mstatus_trap, mstatus_mret, busy
    );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// rtl/cpu6_trap_ctrl.sv - prioritised interrupt / illegal-instruction / mret trap sequencer
module cpu6_trap_ctrl #(
    parameter int                XLEN         = 32,
    parameter int                NIRQ         = 4,
    parameter logic [5*NIRQ-1:0] IRQ_CODES    = {5'd16, 5'd3, 5'd7, 5'd11},
    parameter int                EXC_ILL_CODE = 2
) (
    input  logic             clk,
    input  logic             reset,
    cpu6_trap_ctrl_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REDIRECT} state_t;
    typedef enum logic [1:0] {K_NONE, K_IRQ, K_ILL, K_MRET} kind_t;

    state_t          state;
    kind_t           kind_q;
    logic [4:0]      cause_q;
    logic [XLEN-1:0] pc_q;

    logic [NIRQ-1:0] irq_hit;
    logic [4:0]      irq_code;
    kind_t           ev_kind;
    logic [4:0]      ev_code;
    logic            take;

    // Event selection in IDLE: interrupt (lowest line wins), then illegal, then mret
    always_comb begin
        irq_hit  = bus.irq_pending & bus.irq_enable & {NIRQ{bus.mstatus_mie}};
        irq_code = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_hit[i]) irq_code = IRQ_CODES[5*i +: 5];
        end
        ev_kind = K_NONE;
        ev_code = '0;
        if (|irq_hit) begin
            ev_kind = K_IRQ;
            ev_code = irq_code;
        end else if (bus.excp_illinstr) begin
            ev_kind = K_ILL;
            ev_code = 5'(EXC_ILL_CODE);
        end else if (bus.mret) begin
            ev_kind = K_MRET;
        end
        take = (state == S_IDLE) && (ev_kind != K_NONE) && !reset;
    end

    // Sequencer state and event capture; capture happens only in the take cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            kind_q  <= K_NONE;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state   <= S_DRAIN;
                        kind_q  <= ev_kind;
                        cause_q <= ev_code;
                        pc_q    <= bus.pc_d;
                    end
                end
                S_DRAIN: begin
                    if (bus.drain_ack) state <= S_REDIRECT;
                end
                S_REDIRECT: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] code_off;
    logic [XLEN-1:0] cause_word;

    // Pipeline control, redirect target and CSR strobes; mtvec/mepc are used as seen in REDIRECT
    always_comb begin
        base           = {bus.csr_mtvec[XLEN-1:2], 2'b00};
        code_off       = '0;
        code_off[6:2]  = cause_q;
        cause_word     = '0;
        cause_word[4:0] = cause_q;
        cause_word[XLEN-1] = (kind_q == K_IRQ);

        bus.drain_req    = 1'b0;
        bus.stall_f      = take;
        bus.kill_d       = take;
        bus.flush_pc_ena = 1'b0;
        bus.flush_pc     = '0;
        bus.mepc_we      = 1'b0;
        bus.mepc_wdata   = '0;
        bus.mcause_we    = 1'b0;
        bus.mcause_wdata = '0;
        bus.mstatus_trap = 1'b0;
        bus.mstatus_mret = 1'b0;
        bus.busy         = (state != S_IDLE);

        if (state == S_DRAIN) begin
            bus.drain_req = 1'b1;
            bus.stall_f   = 1'b1;
            bus.kill_d    = 1'b1;
        end else if (state == S_REDIRECT) begin
            bus.kill_d       = 1'b1;
            bus.flush_pc_ena = 1'b1;
            case (kind_q)
                K_IRQ, K_ILL: begin
                    // Exceptions always go to base; only interrupts use the vector table
                    if (kind_q == K_IRQ && bus.csr_mtvec[1:0] == 2'b01)
                        bus.flush_pc = base + code_off;
                    else
                        bus.flush_pc = base;
                    bus.mepc_we      = 1'b1;
                    bus.mepc_wdata   = pc_q;
                    bus.mcause_we    = 1'b1;
                    bus.mcause_wdata = cause_word;
                    bus.mstatus_trap = 1'b1;
                end
                K_MRET: begin
                    bus.flush_pc     = bus.csr_mepc;
                    bus.mstatus_mret = 1'b1;
                end
                default: bus.flush_pc = '0;
            endcase
        end
    end

endmodule
